// File: rtl/sram_block_fetch.sv
// ---------------------------------------------------------------------------
// sram_block_fetch
//
// Copies one BLK x BLK sample block, in raster order, from a plane stored in
// external SRAM into the write port of an embedded dual-port RAM. The block
// start address is computed once when a fetch is accepted. After that, the
// stream addresses come from a running row-base register that is advanced by
// the line stride on each column wrap, so the stream path has no multiplier.
//
// Timing, with cycle 0 as the edge that accepts start:
//   cycle 1+i        : SRAM_address = address of sample i (i = 0..BLK*BLK-1)
//   cycle 3+i        : sample i valid on SRAM_read_data (2-cycle SRAM latency)
//   cycle 4+i        : dpr_we/dpr_address/dpr_write_data register sample i
//   cycle BLK*BLK+4  : done pulse; busy is high from cycle 1 to this cycle
//
// Build option:
//   FETCH_SIGN_EXT_EN  defined   -> samples are sign-extended to DPR_DW
//                      undefined -> samples are zero-extended to DPR_DW
//
// Ports:
//   Clock, Resetn                  system clock, async active-low reset
//   start                          request one block fetch (honoured in IDLE)
//   base_addr, stride              plane base address and samples per line
//   blk_col, blk_row               block coordinates within the plane
//   dpr_base                       first dual-port RAM write address
//   busy, done                     fetch in progress / one-cycle completion
//   SRAM_address, SRAM_we_n        SRAM read address, write enable (always 1)
//   SRAM_read_data                 SRAM read data, 2 cycles after the address
//   dpr_address, dpr_write_data,
//   dpr_we                         dual-port RAM write port
// ---------------------------------------------------------------------------
module sram_block_fetch #(
    parameter int BLK      = 8,
    parameter int SRAM_AW  = 18,
    parameter int DPR_AW   = 7,
    parameter int DPR_DW   = 32,
    parameter int STRIDE_W = 9,
    parameter int COL_W    = 6,
    parameter int ROW_W    = 5
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                start,
    input  logic [SRAM_AW-1:0]  base_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [COL_W-1:0]    blk_col,
    input  logic [ROW_W-1:0]    blk_row,
    input  logic [DPR_AW-1:0]   dpr_base,
    output logic                busy,
    output logic                done,
    output logic [SRAM_AW-1:0]  SRAM_address,
    output logic                SRAM_we_n,
    input  logic [15:0]         SRAM_read_data,
    output logic [DPR_AW-1:0]   dpr_address,
    output logic [DPR_DW-1:0]   dpr_write_data,
    output logic                dpr_we
);

    localparam int N  = BLK * BLK;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [SRAM_AW-1:0]  row_base;   // address of column 0 of the current row
    logic [STRIDE_W-1:0] stride_q;
    logic [CW-1:0]       col_cnt;
    logic [NW-1:0]       iss_cnt;    // samples addressed so far
    logic [NW-1:0]       wr_cnt;     // samples written so far
    logic [DPR_AW-1:0]   wr_addr;    // next dual-port RAM write address

    // issue_v marks a cycle whose SRAM_address is a real read. It is delayed
    // to line up with the returning data: two cycles of SRAM latency plus the
    // cycle in which the sample sits on SRAM_read_data before it is captured.
    logic                issue_v;
    logic                pipe1;
    logic                pipe2;

    // One-off block origin. The multiplies happen only on the accept edge.
    logic [SRAM_AW-1:0]  blk_start;
    assign blk_start = base_addr
                     + SRAM_AW'(SRAM_AW'(blk_row) * SRAM_AW'(BLK) * SRAM_AW'(stride))
                     + SRAM_AW'(SRAM_AW'(blk_col) * SRAM_AW'(BLK));

    logic [DPR_DW-1:0]   sample_ext;
`ifdef FETCH_SIGN_EXT_EN
    assign sample_ext = DPR_DW'($signed(SRAM_read_data));
`else
    assign sample_ext = DPR_DW'(SRAM_read_data);
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            SRAM_address   <= '0;
            SRAM_we_n      <= 1'b1;
            dpr_address    <= '0;
            dpr_write_data <= '0;
            dpr_we         <= 1'b0;
            row_base       <= '0;
            stride_q       <= '0;
            col_cnt        <= '0;
            iss_cnt        <= '0;
            wr_cnt         <= '0;
            wr_addr        <= '0;
            issue_v        <= 1'b0;
            pipe1          <= 1'b0;
            pipe2          <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so that all reads see the
            // pre-edge values; that is what lets issue_v/pipe1/pipe2 act as a
            // shift register and lets the defaults below be overridden.
            SRAM_we_n <= 1'b1;
            done      <= 1'b0;
            issue_v   <= 1'b0;
            pipe1     <= issue_v;
            pipe2     <= pipe1;
            dpr_we    <= pipe2;

            // The write side runs off the delayed valid alone, so it overlaps
            // the tail of ISSUE and all of DRAIN without extra state.
            if (pipe2) begin
                dpr_address    <= wr_addr;
                dpr_write_data <= sample_ext;
                wr_addr        <= wr_addr + DPR_AW'(1);
                wr_cnt         <= wr_cnt + NW'(1);
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        row_base <= blk_start;
                        stride_q <= stride;
                        wr_addr  <= dpr_base;
                        col_cnt  <= '0;
                        iss_cnt  <= '0;
                        wr_cnt   <= '0;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    busy         <= 1'b1;
                    SRAM_address <= row_base + SRAM_AW'(col_cnt);
                    issue_v      <= 1'b1;
                    iss_cnt      <= iss_cnt + NW'(1);
                    if (col_cnt == CW'(BLK - 1)) begin
                        col_cnt  <= '0;
                        row_base <= row_base + SRAM_AW'(stride_q);
                    end else begin
                        col_cnt  <= col_cnt + CW'(1);
                    end
                    if (iss_cnt == NW'(N - 1)) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Leave once the final sample is being written this edge.
                    if (pipe2 && (wr_cnt == NW'(N - 1))) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    // busy holds its value (1) through the done cycle; start
                    // sampled here is ignored because the state is not IDLE.
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_block_fetch.sv
// ---------------------------------------------------------------------------
// tb_sram_block_fetch
//
// Scoreboard bench for sram_block_fetch with its default parameters. A
// behavioural SRAM with 2-cycle read latency feeds the DUT. Whenever the
// stimulus side predicts that a start is accepted, the reference model works
// out the whole transaction from the block geometry: read addresses per
// cycle, dual-port RAM writes per cycle, the busy window and the done cycle.
// The model pushes these into queues. A monitor on the falling clock edge
// pops the queues and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_sram_block_fetch;

    localparam int BLK = 8;
    localparam int N   = BLK * BLK;

`ifdef FETCH_SIGN_EXT_EN
    localparam logic [31:0] FF80_EXT = 32'hFFFFFF80;
`else
    localparam logic [31:0] FF80_EXT = 32'h0000FF80;
`endif

    logic        Clock;
    logic        Resetn;
    logic        start;
    logic [17:0] base_addr;
    logic [8:0]  stride;
    logic [5:0]  blk_col;
    logic [4:0]  blk_row;
    logic [6:0]  dpr_base;
    logic        busy;
    logic        done;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [6:0]  dpr_address;
    logic [31:0] dpr_write_data;
    logic        dpr_we;

    sram_block_fetch dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .start          (start),
        .base_addr      (base_addr),
        .stride         (stride),
        .blk_col        (blk_col),
        .blk_row        (blk_row),
        .dpr_base       (dpr_base),
        .busy           (busy),
        .done           (done),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .dpr_address    (dpr_address),
        .dpr_write_data (dpr_write_data),
        .dpr_we         (dpr_we)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Edge counter: after rising edge e has passed, cyc == e.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    bit ff80_mode = 1'b0;

    function automatic logic [15:0] mem(input logic [17:0] a);
        logic [31:0] h;
        if (ff80_mode) return 16'hFF80;
        h = {14'd0, a} * 32'h9E3779B1;
        return h[27:12];
    endfunction

    // The address driven after edge k is sampled at edge k+1. The data appears
    // after edge k+2 and the DUT captures it at edge k+3.
    logic [15:0] sram_s1;
    always @(posedge Clock) begin
        sram_s1        <= mem(SRAM_address);
        SRAM_read_data <= sram_s1;
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [17:0] addr;
    } addr_ev_t;

    typedef struct {
        int          cyc;
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_ev_t;

    addr_ev_t addr_q[$];
    wr_ev_t   wr_q[$];
    int       done_q[$];
    bit       exp_busy[int];
    int       free_cyc = 0;   // first edge at which a new start is accepted

    function automatic logic [31:0] ext(input logic [15:0] d);
`ifdef FETCH_SIGN_EXT_EN
        return {{16{d[15]}}, d};
`else
        return {16'h0000, d};
`endif
    endfunction

    // Runs at a falling edge, after the inputs for the next rising edge are set.
    task automatic model_step();
        int c0;
        int r;
        int c;
        int full;
        logic [17:0] a;
        if (!(start && Resetn && (cyc + 1 >= free_cyc))) return;
        c0 = cyc + 1;
        for (int i = 0; i < N; i++) begin
            r    = i / BLK;
            c    = i % BLK;
            full = int'(base_addr) + (int'(blk_row) * BLK + r) * int'(stride)
                 + int'(blk_col) * BLK + c;
            a    = 18'(full);
            addr_q.push_back('{cyc: c0 + 1 + i, addr: a});
            wr_q.push_back('{cyc: c0 + 4 + i, addr: 7'(int'(dpr_base) + i), data: ext(mem(a))});
        end
        done_q.push_back(c0 + N + 4);
        for (int k = c0 + 1; k <= c0 + N + 4; k++) exp_busy[k] = 1'b1;
        free_cyc = c0 + N + 5;
    endtask

    task automatic flush_model();
        addr_q.delete();
        wr_q.delete();
        done_q.delete();
        exp_busy.delete();
        free_cyc = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clock) begin
        check("sram_we_n", SRAM_we_n, 1'b1);
        check("busy", busy, exp_busy.exists(cyc));
        if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
            check("sram_address", SRAM_address, addr_q[0].addr);
            void'(addr_q.pop_front());
        end
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            check("dpr_we", dpr_we, 1'b1);
            check("dpr_address", dpr_address, wr_q[0].addr);
            check("dpr_write_data", dpr_write_data, wr_q[0].data);
            void'(wr_q.pop_front());
        end else begin
            check("dpr_we_idle", dpr_we, 1'b0);
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            check("done", done, 1'b1);
            void'(done_q.pop_front());
        end else begin
            check("done_idle", done, 1'b0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_to(input int target);
        while (cyc < target) @(negedge Clock);
    endtask

    task automatic scramble_inputs();
        base_addr = 18'($urandom);
        stride    = 9'($urandom);
        blk_col   = 6'($urandom);
        blk_row   = 5'($urandom);
        dpr_base  = 7'($urandom);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sram_address", SRAM_address, 18'd0);
        check("rst_sram_we_n", SRAM_we_n, 1'b1);
        check("rst_dpr_address", dpr_address, 7'd0);
        check("rst_dpr_write_data", dpr_write_data, 32'd0);
        check("rst_dpr_we", dpr_we, 1'b0);
    endtask

    // Waits for idle, pulses start for one cycle with the given geometry, then
    // scrambles the inputs while the fetch runs. c0 is the accepting edge.
    task automatic start_fetch(input logic [17:0] b, input logic [8:0] s,
                               input logic [5:0] col, input logic [4:0] row,
                               input logic [6:0] db, output int c0);
        wait_to(free_cyc);
        @(negedge Clock);
        base_addr = b;
        stride    = s;
        blk_col   = col;
        blk_row   = row;
        dpr_base  = db;
        start     = 1'b1;
        c0        = cyc + 1;
        model_step();
        @(negedge Clock);
        start = 1'b0;
        scramble_inputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        Resetn    = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        blk_col   = '0;
        blk_row   = '0;
        dpr_base  = '0;
        #1 Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_vals();
        Resetn = 1'b1;

        // Y block (0,0), stride 320
        start_fetch(18'd0, 9'd320, 6'd0, 5'd0, 7'd0, c0);
        wait_to(c0 + 1);  check("y00_first_addr", SRAM_address, 18'd0);
        wait_to(c0 + 9);  check("y00_row1_addr", SRAM_address, 18'd320);
        wait_to(c0 + 64); check("y00_last_addr", SRAM_address, 18'd2247);
        wait_to(c0 + 67); check("y00_last_write", dpr_address, 7'd63);
        wait_to(c0 + 68); check("y00_done", done, 1'b1);

        // Last Y block (39,29)
        start_fetch(18'd0, 9'd320, 6'd39, 5'd29, 7'd0, c0);
        wait_to(c0 + 1);  check("ylast_first_addr", SRAM_address, 18'd74552);
        wait_to(c0 + 64); check("ylast_last_addr", SRAM_address, 18'd76799);

        // U block (1,2), dpr_address wraps past 127
        start_fetch(18'd38400, 9'd160, 6'd1, 5'd2, 7'd96, c0);
        wait_to(c0 + 1);  check("u_first_addr", SRAM_address, 18'd40968);
        wait_to(c0 + 4);  check("u_first_dpr", dpr_address, 7'd96);
        wait_to(c0 + 9);  check("u_row1_addr", SRAM_address, 18'd41128);
        wait_to(c0 + 35); check("u_dpr_top", dpr_address, 7'd127);
        wait_to(c0 + 36); check("u_dpr_wrap", dpr_address, 7'd0);

        // Negative sample extension
        wait_to(free_cyc);
        ff80_mode = 1'b1;
        start_fetch(18'($urandom), 9'($urandom), 6'($urandom), 5'($urandom), 7'($urandom), c0);
        wait_to(c0 + 4);  check("ff80_ext", dpr_write_data, FF80_EXT);
        wait_to(free_cyc);
        ff80_mode = 1'b0;

        // start held high with blk_col changing every cycle
        wait_to(free_cyc);
        @(negedge Clock);
        base_addr = 18'd0;
        stride    = 9'd320;
        blk_row   = 5'd3;
        blk_col   = 6'd5;
        dpr_base  = 7'd10;
        for (int k = 0; k < 3 * (N + 5); k++) begin
            start = 1'b1;
            if (k > 0) blk_col = 6'($urandom);
            model_step();
            @(negedge Clock);
        end
        start = 1'b0;

        // Reset 30 cycles into a fetch, then a full fetch
        start_fetch(18'($urandom), 9'($urandom), 6'($urandom), 5'($urandom), 7'($urandom), c0);
        wait_to(c0 + 30);
        #2;
        Resetn = 1'b0;
        flush_model();
        #1;
        check_reset_vals();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        start_fetch(18'd1000, 9'd200, 6'd2, 5'd1, 7'd120, c0);
        wait_to(c0 + 1);  check("post_rst_first_addr", SRAM_address, 18'd2616);
        wait_to(c0 + 68); check("post_rst_done", done, 1'b1);

        // Random fetches, including address wrap modulo 2^18
        for (int t = 0; t < 6; t++) begin
            start_fetch(18'($urandom), 9'($urandom), 6'($urandom), 5'($urandom), 7'($urandom), c0);
        end
        wait_to(free_cyc + 3);

        check("scoreboard_drained", 64'(addr_q.size() + wr_q.size() + done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
